// File: rtl/fads_pkg.sv
// Shared constants for the FADS sort-pulse scheduler: register map, bit positions,
// reset defaults and the pulse FSM state type.
package fads_pkg;

  localparam logic [19:0] RegCtrl     = 20'h00;
  localparam logic [19:0] RegDelay    = 20'h04;
  localparam logic [19:0] RegDuration = 20'h08;
  localparam logic [19:0] RegStatus   = 20'h0C;
  localparam logic [19:0] RegIssued   = 20'h10;
  localparam logic [19:0] RegDropped  = 20'h14;
  localparam logic [19:0] RegMerged   = 20'h18;

  localparam int unsigned CtrlEnBit     = 0;
  localparam int unsigned CtrlFlushBit  = 1;
  localparam int unsigned StatActiveBit = 16;
  localparam int unsigned StatFullBit   = 17;

  localparam logic [31:0] DelayRst    = 32'd31250;
  localparam logic [31:0] DurationRst = 32'd125000;

  typedef enum logic {StIdle, StActive} pulse_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/red_pitaya_fads_deadline_fifo.sv
// Circular deadline queue (2^QSZ x TW) with wrap-bit pointers, synchronous flush and a
// combinational head word.
module red_pitaya_fads_deadline_fifo #(
  parameter int unsigned QSZ = 3,
  parameter int unsigned TW  = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [TW-1:0] data_i,
  output logic [TW-1:0] head_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [QSZ:0]  fill_o
);

  logic [TW-1:0] mem_q [2**QSZ];
  logic [QSZ:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic          push_ok, pop_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[QSZ] != rptr_q[QSZ]) && (wptr_q[QSZ-1:0] == rptr_q[QSZ-1:0]);
  assign fill_o  = wptr_q - rptr_q;
  assign head_o  = mem_q[rptr_q[QSZ-1:0]];

  // A pop frees the head slot in the same cycle, so a full queue may still accept a push.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wptr_q[QSZ-1:0]] <= data_i;
  end

endmodule

// File: rtl/red_pitaya_fads_sort_sched.sv
// FADS sort-pulse scheduler: timestamps sort requests, queues deadlines and emits sort pulses.
// Define FADS_SORT_MERGE_EN to extend an active pulse when the next deadline falls inside it.
module red_pitaya_fads_sort_sched import fads_pkg::*; #(
  parameter int unsigned QSZ = 3,
  parameter int unsigned TW  = 32
) (
  input  logic        adc_clk_i,
  input  logic        adc_rst_i,
  input  logic        sort_req_i,
  output logic        sort_trig_o,
  output logic        busy_o,
  input  logic [31:0] sys_addr,
  input  logic [31:0] sys_wdata,
  input  logic [3:0]  sys_sel,
  input  logic        sys_wen,
  input  logic        sys_ren,
  output logic [31:0] sys_rdata,
  output logic        sys_err,
  output logic        sys_ack
);

  localparam logic [TW-1:0] DelayMax = {1'b0, {(TW-1){1'b1}}};

  logic [TW-1:0] now_q, now_d, delay_q, delay_d, duration_q, duration_d, cnt_q, cnt_d;
  logic [31:0]   issued_q, issued_d, dropped_q, dropped_d, merged_q, merged_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          en_q, en_d, trig_q, ack_q;
  pulse_state_e  state_q, state_d;

  logic [19:0]   addr;
  logic [TW-1:0] head, age, delay_clamp, delay_eff, dur_eff;
  logic [QSZ:0]  fill;
  logic          empty, full, due, push, pop, flush, clr_cnt, wr_ctrl;
  logic          inc_issued, inc_dropped, inc_merged;
  logic          unused_bus;

  assign unused_bus = ^{sys_sel, sys_addr[31:20]};
  assign addr       = sys_addr[19:0];

  assign wr_ctrl = sys_wen && (addr == RegCtrl);
  // Flush bit or an enable 1->0 transition both empty the queue and abort the pulse.
  assign flush   = wr_ctrl && (sys_wdata[CtrlFlushBit] || (en_q && !sys_wdata[CtrlEnBit]));
  assign clr_cnt = sys_wen && (addr == RegIssued || addr == RegDropped || addr == RegMerged);

  assign delay_clamp = (delay_q > DelayMax) ? DelayMax : delay_q;
  assign delay_eff   = (delay_clamp < TW'(2)) ? TW'(2) : delay_clamp;
  assign dur_eff     = (duration_q == '0) ? TW'(1) : duration_q;
  assign age         = now_q - head;
  assign due         = !empty && !age[TW-1];
  assign push        = sort_req_i && en_q && !flush;
  assign now_d       = now_q + 1'b1;

  red_pitaya_fads_deadline_fifo #(.QSZ(QSZ), .TW(TW)) u_fifo (
    .clk_i   (adc_clk_i),
    .rst_i   (adc_rst_i),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (now_q + delay_eff),
    .head_o  (head),
    .empty_o (empty),
    .full_o  (full),
    .fill_o  (fill)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pop         = 1'b0;
    inc_issued  = 1'b0;
    inc_dropped = 1'b0;
    inc_merged  = 1'b0;
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (due) begin
            pop        = 1'b1;
            cnt_d      = dur_eff;
            inc_issued = 1'b1;
            state_d    = StActive;
          end
        end
        StActive: begin
          // A deadline landing on the last active cycle starts a fresh back-to-back pulse.
          if (cnt_q == TW'(1)) begin
            if (due) begin
              pop        = 1'b1;
              cnt_d      = dur_eff;
              inc_issued = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
            if (due) begin
              pop = 1'b1;
`ifdef FADS_SORT_MERGE_EN
              cnt_d      = dur_eff;
              inc_merged = 1'b1;
`else
              inc_dropped = 1'b1;
`endif
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (push && full && !pop) inc_dropped = 1'b1;
  end

  always_comb begin
    en_d       = wr_ctrl ? sys_wdata[CtrlEnBit] : en_q;
    delay_d    = (sys_wen && addr == RegDelay) ? TW'(sys_wdata) : delay_q;
    duration_d = (sys_wen && addr == RegDuration) ? TW'(sys_wdata) : duration_q;
    issued_d   = clr_cnt ? '0 : (inc_issued ? sat_inc(issued_q) : issued_q);
    dropped_d  = clr_cnt ? '0 : (inc_dropped ? sat_inc(dropped_q) : dropped_q);
    merged_d   = clr_cnt ? '0 : (inc_merged ? sat_inc(merged_q) : merged_q);
    rdata_d    = '0;
    if (sys_ren) begin
      case (addr)
        RegCtrl:     rdata_d[CtrlEnBit] = en_q;
        RegDelay:    rdata_d = 32'(delay_q);
        RegDuration: rdata_d = 32'(duration_q);
        RegStatus: begin
          rdata_d[QSZ:0]         = fill;
          rdata_d[StatActiveBit] = (state_q == StActive);
          rdata_d[StatFullBit]   = full;
        end
        RegIssued:   rdata_d = issued_q;
        RegDropped:  rdata_d = dropped_q;
        RegMerged:   rdata_d = merged_q;
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      now_q      <= '0;
      en_q       <= 1'b0;
      delay_q    <= TW'(DelayRst);
      duration_q <= TW'(DurationRst);
      issued_q   <= '0;
      dropped_q  <= '0;
      merged_q   <= '0;
      state_q    <= StIdle;
      cnt_q      <= '0;
      trig_q     <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      now_q      <= now_d;
      en_q       <= en_d;
      delay_q    <= delay_d;
      duration_q <= duration_d;
      issued_q   <= issued_d;
      dropped_q  <= dropped_d;
      merged_q   <= merged_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      trig_q     <= (state_d == StActive);
      ack_q      <= sys_wen | sys_ren;
      rdata_q    <= rdata_d;
    end
  end

  assign sort_trig_o = trig_q;
  assign busy_o      = !empty || (state_q == StActive);
  assign sys_rdata   = rdata_q;
  assign sys_ack     = ack_q;
  assign sys_err     = 1'b0;

endmodule
